// File: rtl/lspc_irq_ctrl.sv
// lspc_irq_ctrl
// Register-side controller for the LSPC horizontal timer and the 68k
// interrupt sources (reset, timer, vblank). Decodes CPU writes to the
// LSPCMODE, timer-load, IRQACK and TIMERSTOP offsets, drives the timer
// load strobes and mode controls, latches interrupt requests on rising
// edges and presents the highest pending level on IPL.
//
// Build option: define LSPC_TIMER_STOP_EN to implement the TIMERSTOP
// register at offset 7. Without it TIMER_STOP is tied low and writes to
// offset 7 are ignored.
module lspc_irq_ctrl (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        REG_WE,
    input  logic [2:0]  REG_ADDR,
    input  logic [15:0] M68K_DATA,
    input  logic        TIMER_IRQ,
    input  logic        VBLANK,
    output logic        WR_TIMER_HIGH,
    output logic        WR_TIMER_LOW,
    output logic [15:0] TIMER_DATA,
    output logic [2:0]  TIMER_MODE,
    output logic        TIMER_IRQ_EN,
    output logic        TIMER_STOP,
    output logic        AA_DISABLE,
    output logic [7:0]  AA_SPEED,
    output logic [2:0]  IPL
);

    // Register offsets within the LSPC window
    localparam logic [2:0] ADDR_LSPCMODE  = 3'd3;
    localparam logic [2:0] ADDR_TIMER_HI  = 3'd4;
    localparam logic [2:0] ADDR_TIMER_LO  = 3'd5;
    localparam logic [2:0] ADDR_IRQACK    = 3'd6;
    localparam logic [2:0] ADDR_TIMERSTOP = 3'd7;

    // Interrupt levels as seen by the 68k encoder
    localparam logic [2:0] LEVEL_NONE   = 3'd0;
    localparam logic [2:0] LEVEL_VBLANK = 3'd1;
    localparam logic [2:0] LEVEL_TIMER  = 3'd2;
    localparam logic [2:0] LEVEL_RESET  = 3'd3;

    // Write decode
    logic sel_mode;
    logic sel_timer_hi;
    logic sel_timer_lo;
    logic sel_ack;

    // Pending interrupt flags and edge-history registers
    logic pend_rst;
    logic pend_tmr;
    logic pend_vbl;
    logic tmr_hist;
    logic vbl_hist;

    // Next-state values for the pending flags
    logic tmr_rise;
    logic vbl_rise;
    logic ack_rst;
    logic ack_tmr;
    logic ack_vbl;
    logic pend_rst_next;
    logic pend_tmr_next;
    logic pend_vbl_next;
    logic [2:0] ipl_next;

    // Address decode, qualified by the write strobe
    always_comb begin
        sel_mode     = REG_WE && (REG_ADDR == ADDR_LSPCMODE);
        sel_timer_hi = REG_WE && (REG_ADDR == ADDR_TIMER_HI);
        sel_timer_lo = REG_WE && (REG_ADDR == ADDR_TIMER_LO);
        sel_ack      = REG_WE && (REG_ADDR == ADDR_IRQACK);
    end

    // Edge detection and pending-flag update; a set in the same cycle as
    // an ack of the same flag wins so no interrupt event is ever dropped
    always_comb begin
        tmr_rise = TIMER_IRQ & ~tmr_hist;
        vbl_rise = VBLANK & ~vbl_hist;

        ack_rst = sel_ack & M68K_DATA[0];
        ack_tmr = sel_ack & M68K_DATA[1];
        ack_vbl = sel_ack & M68K_DATA[2];

        // Reset requests are only raised by RESET itself
        pend_rst_next = pend_rst & ~ack_rst;
        pend_tmr_next = tmr_rise | (pend_tmr & ~ack_tmr);
        pend_vbl_next = vbl_rise | (pend_vbl & ~ack_vbl);
    end

    // Priority encode of the current flags: reset > timer > vblank
    always_comb begin
        ipl_next = LEVEL_NONE;
        if (pend_rst) begin
            ipl_next = LEVEL_RESET;
        end else if (pend_tmr) begin
            ipl_next = LEVEL_TIMER;
        end else if (pend_vbl) begin
            ipl_next = LEVEL_VBLANK;
        end
    end

    // Interrupt state: history, pending flags and the registered level
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            tmr_hist <= 1'b0;
            vbl_hist <= 1'b0;
            pend_rst <= 1'b1;
            pend_tmr <= 1'b0;
            pend_vbl <= 1'b0;
            IPL      <= LEVEL_RESET;
        end else begin
            tmr_hist <= TIMER_IRQ;
            vbl_hist <= VBLANK;
            pend_rst <= pend_rst_next;
            pend_tmr <= pend_tmr_next;
            pend_vbl <= pend_vbl_next;
            IPL      <= ipl_next;
        end
    end

    // Timer load strobes and the data word that goes with them; the data
    // is held between writes so the timer can sample it late if it wants
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            WR_TIMER_HIGH <= 1'b0;
            WR_TIMER_LOW  <= 1'b0;
            TIMER_DATA    <= 16'h0000;
        end else begin
            WR_TIMER_HIGH <= sel_timer_hi;
            WR_TIMER_LOW  <= sel_timer_lo;
            if (sel_timer_hi || sel_timer_lo) begin
                TIMER_DATA <= M68K_DATA;
            end
        end
    end

    // LSPCMODE fields: auto-animation and timer mode controls
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            AA_SPEED     <= 8'h00;
            TIMER_MODE   <= 3'b000;
            TIMER_IRQ_EN <= 1'b0;
            AA_DISABLE   <= 1'b0;
        end else if (sel_mode) begin
            AA_SPEED     <= M68K_DATA[15:8];
            TIMER_MODE   <= M68K_DATA[7:5];
            TIMER_IRQ_EN <= M68K_DATA[4];
            AA_DISABLE   <= M68K_DATA[3];
        end
    end

`ifdef LSPC_TIMER_STOP_EN
    logic sel_stop;

    // TIMERSTOP decode
    always_comb begin
        sel_stop = REG_WE && (REG_ADDR == ADDR_TIMERSTOP);
    end

    // TIMERSTOP register: halts the timer in non-displayed lines on PAL
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            TIMER_STOP <= 1'b0;
        end else if (sel_stop) begin
            TIMER_STOP <= M68K_DATA[0];
        end
    end
`else
    // No TIMERSTOP register in this build
    assign TIMER_STOP = 1'b0;
`endif

endmodule
